// File: rtl/cfi_lp_checker.sv
// -----------------------------------------------------------------------------
// cfi_lp_checker
//
// Commit-side forward-edge control-flow-integrity checker. It watches the
// committed instruction stream and tracks the three landing-pad label
// registers (upper, middle, lower). These registers are written by LPSLL, SML
// and SUL. Every committed indirect jump must be followed by a landing-pad
// sequence: LPCLL, optionally followed by CUL and then CML. All labels in the
// sequence must match. Any miss or mismatch raises a registered one-cycle
// violation pulse, which carries the PC and a cause code, and sets a sticky
// fault bit.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   en_i               enforcement enable
//   flush_i            pipeline flush; drops any pending expectation and
//                      ignores the commit in the same cycle
//   commit_valid_i     one instruction committed this cycle
//   commit_instr_i     committed instruction (compressed ones in [15:0])
//   commit_pc_i        PC of the committed instruction
//   clear_i            clears the sticky fault
//   violation_o        one-cycle violation pulse (registered)
//   violation_pc_o     PC of the offending instruction, held until the next
//                      violation
//   violation_cause_o  01 missing LP, 10 lower-label mismatch,
//                      11 upper/middle-label mismatch
//   fault_sticky_o     sticky fault flag
//   label_o            {upper[7:0], middle[7:0], lower[8:0]}
// -----------------------------------------------------------------------------
module cfi_lp_checker #(
   parameter int unsigned XLEN          = 64,
   parameter bit          CHECK_RETURNS = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            flush_i,
   input  logic            commit_valid_i,
   input  logic [31:0]     commit_instr_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic            clear_i,
   output logic            violation_o,
   output logic [XLEN-1:0] violation_pc_o,
   output logic [1:0]      violation_cause_o,
   output logic            fault_sticky_o,
   output logic [24:0]     label_o
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LP_EXPECT = 2'd1;
   localparam logic [1:0] LP_UPPER  = 2'd2;
   localparam logic [1:0] LP_MIDDLE = 2'd3;

   localparam logic [1:0] CAUSE_MISSING = 2'b01;
   localparam logic [1:0] CAUSE_LOWER   = 2'b10;
   localparam logic [1:0] CAUSE_UPPER   = 2'b11;

   // ---------------------------------------------------------------------
   // Instruction decode
   // ---------------------------------------------------------------------
   logic       is_sys_s;
   logic       is_lp_grp_s;
   logic       is_lbl_grp_s;
   logic       is_lpcll_s;
   logic       is_lpsll_s;
   logic       is_sml_s;
   logic       is_cml_s;
   logic       is_sul_s;
   logic       is_cul_s;
   logic [8:0] label9_s;
   logic [7:0] label8_s;
   logic       is_jalr32_s;
   logic       is_cjr_s;
   logic [4:0] jmp_rs1_s;
   logic       is_return_s;
   logic       is_indirect_s;

   assign is_sys_s     = (commit_instr_i[6:0] == 7'b1110011) &&
                         (commit_instr_i[14:12] == 3'b100) &&
                         (commit_instr_i[11:7] == 5'd0);
   assign is_lp_grp_s  = is_sys_s && (commit_instr_i[31:25] == 7'b1000001);
   assign is_lbl_grp_s = is_sys_s && (commit_instr_i[31:25] == 7'b1000011);

   assign is_lpcll_s = is_lp_grp_s &&  commit_instr_i[24];
   assign is_lpsll_s = is_lp_grp_s && !commit_instr_i[24];
   assign is_sml_s   = is_lbl_grp_s && (commit_instr_i[24:23] == 2'b00);
   assign is_cml_s   = is_lbl_grp_s && (commit_instr_i[24:23] == 2'b01);
   assign is_sul_s   = is_lbl_grp_s && (commit_instr_i[24:23] == 2'b10);
   assign is_cul_s   = is_lbl_grp_s && (commit_instr_i[24:23] == 2'b11);

   assign label9_s = commit_instr_i[23:15];
   assign label8_s = commit_instr_i[22:15];

   // A 32-bit JALR has [1:0]=11, so it cannot alias a compressed encoding.
   assign is_jalr32_s = (commit_instr_i[6:0] == 7'b1100111) &&
                        (commit_instr_i[14:12] == 3'b000);
   // C.JR and C.JALR differ only in bit 12; both are indirect jumps.
   assign is_cjr_s    = (commit_instr_i[1:0] == 2'b10) &&
                        (commit_instr_i[15:13] == 3'b100) &&
                        (commit_instr_i[6:2] == 5'd0) &&
                        (commit_instr_i[11:7] != 5'd0);
   assign jmp_rs1_s   = is_jalr32_s ? commit_instr_i[19:15] : commit_instr_i[11:7];
   assign is_return_s = (jmp_rs1_s == 5'd1) || (jmp_rs1_s == 5'd5);
   assign is_indirect_s = (is_jalr32_s || is_cjr_s) &&
                          (CHECK_RETURNS || !is_return_s);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]      state_q, state_d;
   logic [8:0]      lower_q, lower_d;
   logic [7:0]      middle_q, middle_d;
   logic [7:0]      upper_q, upper_d;
   logic            violation_q, violation_d;
   logic [XLEN-1:0] vpc_q, vpc_d;
   logic [1:0]      cause_q, cause_d;
   logic            sticky_q, sticky_d;
   logic [1:0]      idle_next_s;

   // Next state when the current instruction is evaluated as if in IDLE.
   assign idle_next_s = is_indirect_s ? LP_EXPECT : IDLE;

   // Landing-pad FSM next state and violation detection.
   always_comb begin
      state_d     = state_q;
      violation_d = 1'b0;
      cause_d     = 2'b00;
      if (flush_i) begin
         state_d = IDLE;
      end else if (!en_i) begin
         state_d = IDLE;
      end else if (commit_valid_i) begin
         case (state_q)
            IDLE: begin
               state_d = idle_next_s;
            end
            LP_EXPECT: begin
               state_d     = IDLE;
               violation_d = 1'b1;
               if (is_lpcll_s) begin
                  if (label9_s == lower_q) begin
                     state_d     = LP_UPPER;
                     violation_d = 1'b0;
                  end else begin
                     cause_d = CAUSE_LOWER;
                  end
               end else begin
                  cause_d = CAUSE_MISSING;
               end
            end
            LP_UPPER: begin
               if (is_cul_s) begin
                  if (label8_s == upper_q) begin
                     state_d = LP_MIDDLE;
                  end else begin
                     state_d     = IDLE;
                     violation_d = 1'b1;
                     cause_d     = CAUSE_UPPER;
                  end
               end else begin
                  state_d = idle_next_s;
               end
            end
            LP_MIDDLE: begin
               if (is_cml_s) begin
                  state_d = IDLE;
                  if (label8_s != middle_q) begin
                     violation_d = 1'b1;
                     cause_d     = CAUSE_UPPER;
                  end else begin
                     violation_d = 1'b0;
                  end
               end else begin
                  state_d = idle_next_s;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Label register writes. They ignore en_i, but a flushed commit is dropped.
   always_comb begin
      lower_d  = lower_q;
      middle_d = middle_q;
      upper_d  = upper_q;
      if (commit_valid_i && !flush_i) begin
         if (is_lpsll_s) begin
            lower_d = label9_s;
         end else if (is_sml_s) begin
            middle_d = label8_s;
         end else if (is_sul_s) begin
            upper_d = label8_s;
         end else begin
            lower_d = lower_q;
         end
      end else begin
         lower_d = lower_q;
      end
   end

   // Violation report registers. A new violation overrides clear_i.
   always_comb begin
      vpc_d = violation_d ? commit_pc_i : vpc_q;
      if (violation_d) begin
         sticky_d = 1'b1;
      end else if (clear_i) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // All state and output flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         lower_q     <= 9'd0;
         middle_q    <= 8'd0;
         upper_q     <= 8'd0;
         violation_q <= 1'b0;
         vpc_q       <= {XLEN{1'b0}};
         cause_q     <= 2'b00;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lower_q     <= lower_d;
         middle_q    <= middle_d;
         upper_q     <= upper_d;
         violation_q <= violation_d;
         vpc_q       <= vpc_d;
         cause_q     <= violation_d ? cause_d : cause_q;
         sticky_q    <= sticky_d;
      end
   end

   assign violation_o       = violation_q;
   assign violation_pc_o    = vpc_q;
   assign violation_cause_o = cause_q;
   assign fault_sticky_o    = sticky_q;
   assign label_o           = {upper_q, middle_q, lower_q};

endmodule

// File: tb/tb_cfi_lp_checker.sv
// -----------------------------------------------------------------------------
// tb_cfi_lp_checker
//
// Directed testbench for cfi_lp_checker. Instructions are driven on the
// falling edge and held for one clock. The registered outputs are then
// sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_cfi_lp_checker;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i;
   logic        flush_i;
   logic        commit_valid_i;
   logic [31:0] commit_instr_i;
   logic [63:0] commit_pc_i;
   logic        clear_i;
   logic        violation_o;
   logic [63:0] violation_pc_o;
   logic [1:0]  violation_cause_o;
   logic        fault_sticky_o;
   logic [24:0] label_o;

   int n_vec  = 0;
   int n_miss = 0;

   cfi_lp_checker #(.XLEN(64), .CHECK_RETURNS(1'b0)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .en_i              (en_i),
      .flush_i           (flush_i),
      .commit_valid_i    (commit_valid_i),
      .commit_instr_i    (commit_instr_i),
      .commit_pc_i       (commit_pc_i),
      .clear_i           (clear_i),
      .violation_o       (violation_o),
      .violation_pc_o    (violation_pc_o),
      .violation_cause_o (violation_cause_o),
      .fault_sticky_o    (fault_sticky_o),
      .label_o           (label_o)
   );

   always #5 clk_i = ~clk_i;

   // Instruction encoders
   function automatic logic [31:0] lpsll(input logic [8:0] l);
      return {7'b1000001, 1'b0, l, 3'b100, 5'd0, 7'b1110011};
   endfunction
   function automatic logic [31:0] lpcll(input logic [8:0] l);
      return {7'b1000001, 1'b1, l, 3'b100, 5'd0, 7'b1110011};
   endfunction
   function automatic logic [31:0] lbl8(input logic [1:0] op, input logic [7:0] l);
      return {7'b1000011, op, l, 3'b100, 5'd0, 7'b1110011};
   endfunction
   function automatic logic [31:0] jalr(input logic [4:0] rs1);
      return {12'd0, rs1, 3'b000, 5'd0, 7'b1100111};
   endfunction
   function automatic logic [31:0] cjr(input logic link, input logic [4:0] rs1);
      return {16'h0000, 3'b100, link, rs1, 5'd0, 2'b10};
   endfunction

   localparam logic [1:0] OP_SML = 2'b00;
   localparam logic [1:0] OP_CML = 2'b01;
   localparam logic [1:0] OP_SUL = 2'b10;
   localparam logic [1:0] OP_CUL = 2'b11;
   localparam logic [31:0] ADDI = {12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one commit for a single clock; returns on the next falling edge.
   task automatic commit(input logic [31:0] ins, input logic [63:0] pc);
      commit_valid_i = 1'b1;
      commit_instr_i = ins;
      commit_pc_i    = pc;
      @(negedge clk_i);
      commit_valid_i = 1'b0;
      commit_instr_i = 32'd0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; en_i = 1'b1; flush_i = 1'b0; commit_valid_i = 1'b0;
      commit_instr_i = 32'd0; commit_pc_i = 64'd0; clear_i = 1'b0;
      @(negedge clk_i); @(negedge clk_i);
      check_eq("rst_viol",   {63'd0, violation_o}, 64'd0);
      check_eq("rst_pc",     violation_pc_o, 64'd0);
      check_eq("rst_cause",  {62'd0, violation_cause_o}, 64'd0);
      check_eq("rst_sticky", {63'd0, fault_sticky_o}, 64'd0);
      check_eq("rst_label",  {39'd0, label_o}, 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Matching lower label
      commit(lpsll(9'h0A5), 64'h100); check_eq("t1_lpsll", {63'd0, violation_o}, 64'd0);
      commit(jalr(5'd6), 64'h104);    check_eq("t1_jalr",  {63'd0, violation_o}, 64'd0);
      commit(lpcll(9'h0A5), 64'h108); check_eq("t1_lpcll", {63'd0, violation_o}, 64'd0);
      check_eq("t1_label", {55'd0, label_o[8:0]}, 64'h0A5);
      commit(ADDI, 64'h10C);          check_eq("t1_addi1", {63'd0, violation_o}, 64'd0);
      commit(ADDI, 64'h110);          check_eq("t1_addi2", {63'd0, violation_o}, 64'd0);
      check_eq("t1_sticky", {63'd0, fault_sticky_o}, 64'd0);

      // Lower label mismatch
      commit(jalr(5'd6), 64'h200);
      commit(lpcll(9'h0A4), 64'h204);
      check_eq("t2_viol",   {63'd0, violation_o}, 64'd1);
      check_eq("t2_cause",  {62'd0, violation_cause_o}, 64'd2);
      check_eq("t2_pc",     violation_pc_o, 64'h204);
      check_eq("t2_sticky", {63'd0, fault_sticky_o}, 64'd1);
      commit(ADDI, 64'h208);
      check_eq("t2_pulse",   {63'd0, violation_o}, 64'd0);
      check_eq("t2_sticky2", {63'd0, fault_sticky_o}, 64'd1);
      check_eq("t2_pchold",  violation_pc_o, 64'h204);
      do_clear();
      check_eq("t2_clear", {63'd0, fault_sticky_o}, 64'd0);

      // Full sequence with middle mismatch, then match
      commit(lbl8(OP_SUL, 8'h3C), 64'h300);
      commit(lbl8(OP_SML, 8'h11), 64'h304);
      commit(lpsll(9'h001), 64'h308);
      check_eq("t3_label", {39'd0, label_o}, {39'd0, 8'h3C, 8'h11, 9'h001});
      commit(cjr(1'b1, 5'd7), 64'h30C);
      commit(lpcll(9'h001), 64'h310);
      commit(lbl8(OP_CUL, 8'h3C), 64'h314);
      check_eq("t3_cul_ok", {63'd0, violation_o}, 64'd0);
      commit(lbl8(OP_CML, 8'h12), 64'h318);
      check_eq("t3_viol",  {63'd0, violation_o}, 64'd1);
      check_eq("t3_cause", {62'd0, violation_cause_o}, 64'd3);
      check_eq("t3_pc",    violation_pc_o, 64'h318);
      commit(cjr(1'b1, 5'd7), 64'h320);
      commit(lpcll(9'h001), 64'h324);
      commit(lbl8(OP_CUL, 8'h3C), 64'h328);
      commit(lbl8(OP_CML, 8'h11), 64'h32C);
      check_eq("t3_ok", {63'd0, violation_o}, 64'd0);
      check_eq("t3_label2", {39'd0, label_o}, {39'd0, 8'h3C, 8'h11, 9'h001});
      do_clear();

      // Upper label mismatch
      commit(jalr(5'd6), 64'h340);
      commit(lpcll(9'h001), 64'h344);
      commit(lbl8(OP_CUL, 8'h3D), 64'h348);
      check_eq("t3b_viol",  {63'd0, violation_o}, 64'd1);
      check_eq("t3b_cause", {62'd0, violation_cause_o}, 64'd3);
      check_eq("t3b_pc",    violation_pc_o, 64'h348);
      do_clear();

      // Jump in LP_UPPER re-arms the expectation
      commit(jalr(5'd6), 64'h350);
      commit(lpcll(9'h001), 64'h354);
      commit(cjr(1'b0, 5'd7), 64'h358);
      check_eq("t3c_jr", {63'd0, violation_o}, 64'd0);
      commit(ADDI, 64'h35C);
      check_eq("t3c_viol",  {63'd0, violation_o}, 64'd1);
      check_eq("t3c_cause", {62'd0, violation_cause_o}, 64'd1);
      check_eq("t3c_pc",    violation_pc_o, 64'h35C);
      do_clear();

      // Missing landing pad; returns are exempt
      commit(cjr(1'b0, 5'd7), 64'h400);
      commit(ADDI, 64'h404);
      check_eq("t4_viol",  {63'd0, violation_o}, 64'd1);
      check_eq("t4_cause", {62'd0, violation_cause_o}, 64'd1);
      check_eq("t4_pc",    violation_pc_o, 64'h404);
      do_clear();
      commit(jalr(5'd1), 64'h410);
      commit(ADDI, 64'h414);
      check_eq("t4_ret", {63'd0, violation_o}, 64'd0);
      commit(cjr(1'b0, 5'd5), 64'h418);
      commit(ADDI, 64'h41C);
      check_eq("t4_ret5", {63'd0, violation_o}, 64'd0);

      // Flush drops the expectation and the flushed commit
      commit(jalr(5'd6), 64'h500);
      flush_i = 1'b1;
      commit(lpsll(9'h055), 64'h504);
      flush_i = 1'b0;
      check_eq("t5_flush", {63'd0, violation_o}, 64'd0);
      check_eq("t5_flabel", {55'd0, label_o[8:0]}, 64'h001);
      commit(ADDI, 64'h508);
      check_eq("t5_addi", {63'd0, violation_o}, 64'd0);
      en_i = 1'b0;
      commit(jalr(5'd6), 64'h510);
      commit(ADDI, 64'h514);
      check_eq("t5_dis", {63'd0, violation_o}, 64'd0);
      commit(lpsll(9'h1FF), 64'h518);
      check_eq("t5_dlabel", {55'd0, label_o[8:0]}, 64'h1FF);
      en_i = 1'b1;
      check_eq("t5_sticky", {63'd0, fault_sticky_o}, 64'd0);

      // Violation beats clear in the same cycle
      commit(jalr(5'd6), 64'h600);
      clear_i = 1'b1;
      commit(ADDI, 64'h604);
      clear_i = 1'b0;
      check_eq("t6_viol",   {63'd0, violation_o}, 64'd1);
      check_eq("t6_sticky", {63'd0, fault_sticky_o}, 64'd1);

      // Asynchronous reset while a landing pad is expected
      commit(jalr(5'd6), 64'h610);
      rst_ni = 1'b0;
      #1;
      check_eq("t7_viol",   {63'd0, violation_o}, 64'd0);
      check_eq("t7_pc",     violation_pc_o, 64'd0);
      check_eq("t7_cause",  {62'd0, violation_cause_o}, 64'd0);
      check_eq("t7_sticky", {63'd0, fault_sticky_o}, 64'd0);
      check_eq("t7_label",  {39'd0, label_o}, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      commit(ADDI, 64'h620);
      check_eq("t7_addi",    {63'd0, violation_o}, 64'd0);
      check_eq("t7_sticky2", {63'd0, fault_sticky_o}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cfi_lp_checker.md
Name: cfi_lp_checker

Overview:
Commit-side forward-edge CFI enforcement unit. It observes every committed instruction word at the commit port, the same stream the instruction tracer consumes. It tracks the label registers written by LPSLL/SML/SUL. After each committed indirect jump it requires a landing-pad sequence (LPCLL, optionally followed by CUL and then CML) with matching labels. On any miss or mismatch it raises a registered violation with PC and cause for the exception/CSR logic.

Parameters:
XLEN, 64, width of the commit PC and violation PC.
CHECK_RETURNS, 0, if 1, returns (jalr/c.jr with rs1=x1 or x5) also require a landing pad.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  CFI enforcement enable (CSR bit)
flush_i  in  1  pipeline flush/exception; abandons any pending landing-pad expectation
commit_valid_i  in  1  one committed instruction this cycle
commit_instr_i  in  32  committed instruction; compressed ones occupy bits [15:0], upper bits ignored
commit_pc_i  in  XLEN  PC of committed instruction
clear_i  in  1  clears sticky fault (CSR write)
violation_o  out  1  one-cycle pulse, registered
violation_pc_o  out  XLEN  PC of offending instruction, held until next violation
violation_cause_o  out  2  01 missing LP, 10 lower-label mismatch, 11 upper/middle mismatch
fault_sticky_o  out  1  set on violation, cleared by clear_i
label_o  out  25  {upper[7:0], middle[7:0], lower[8:0]} current label registers (debug)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; labels 0; violation_o 0, violation_pc_o 0, violation_cause_o 0, fault_sticky_o 0.
- Decode (opcode 7'b1110011, funct3 100, rd 0):
  - [31:25]=1000001: [24]=1 LPCLL, [24]=0 LPSLL; label9 is [23:15].
  - [31:25]=1000011: [24:23]=00 SML, 01 CML, 10 SUL, 11 CUL; label8 is [22:15].
- Indirect jump:
  - 32-bit JALR (opcode 1100111, funct3 000).
  - C.JR/C.JALR ([1:0]=10, [15:13]=100, [6:2]=0, [11:7]!=0).
  - With CHECK_RETURNS=0, jumps with rs1 equal to x1 or x5 are excluded.
- Label writes: LPSLL, SML and SUL write their label field on commit in any state, regardless of en_i, except when flush_i is high.
- FSM (advances only on commit_valid_i=1 and en_i=1):
  - IDLE: indirect jump → LP_EXPECT. Any other instruction → IDLE.
  - LP_EXPECT:
    - LPCLL with label9 == lower → LP_UPPER.
    - LPCLL mismatch → violation cause 10, → IDLE.
    - Any other instruction → violation cause 01, → IDLE. This includes set instructions; their label write still occurs.
  - LP_UPPER:
    - CUL equal to upper → LP_MIDDLE.
    - CUL unequal → violation cause 11, → IDLE.
    - Any other instruction: the sequence ends OK and the instruction is evaluated as in IDLE in the same cycle (indirect jump → LP_EXPECT, else IDLE).
  - LP_MIDDLE:
    - CML equal to middle → IDLE.
    - CML unequal → violation cause 11, → IDLE.
    - Other instructions: handled as in LP_UPPER.
  - CUL/CML/LPCLL committed in IDLE: no check, no violation.
- Violation timing: violation_o pulses exactly one cycle after the offending commit. violation_pc_o and violation_cause_o update in that same cycle. fault_sticky_o is set in that same cycle.
- Label compares use the label register value before any write in the same cycle.
- en_i=0: state forced to IDLE next cycle; no violations generated.
- flush_i=1: state → IDLE; a commit in the same cycle is ignored entirely (no check, no label write); labels are retained.
- clear_i and a new violation in the same cycle: violation wins, fault_sticky_o stays 1.
- commit_valid_i=0: state, labels and outputs hold; violation_o=0.
- Reset mid-sequence: the pending expectation is lost and labels return to 0.

Test Plan:
- LPSLL label 9'h0A5, then jalr x0,0(x6), then LPCLL 9'h0A5 → no violation; state IDLE after the next non-CUL commit; label_o[8:0]=9'h0A5.
- Same setup with LPCLL 9'h0A4 → violation_o pulses 1 cycle after the LPCLL commit; cause 2'b10; violation_pc_o equals the LPCLL PC; fault_sticky_o=1 until clear_i.
- SUL 8'h3C, SML 8'h11, LPSLL 9'h001, then c.jalr x7, then LPCLL 9'h001, CUL 8'h3C, CML 8'h12 → cause 2'b11 at the CML PC. Repeat with CML 8'h11 → no violation.
- c.jr x7 followed by addi → cause 2'b01. Then jalr x0,0(x1) followed by addi with CHECK_RETURNS=0 → no violation.
- jalr x0,0(x6), then flush_i together with the next commit, then addi → no violation. Separately, en_i=0 over a jalr then addi → no violation, but LPSLL 9'h1FF still updates label_o[8:0].
- rst_ni asserted while in LP_EXPECT → all outputs 0 immediately (async). After release, addi → no violation.
